// File: rtl/wb_burst_mem_slave.sv
// wb_burst_mem_slave: Wishbone B3 slave memory with programmable wait states,
// registered-feedback bursts (const, linear, wrap4/8/16) and err termination
// for accesses whose word index lies outside the memory.
module wb_burst_mem_slave #(
  parameter int DW          = 32,
  parameter int AW          = 32,
  parameter int DEPTH       = 1024,
  parameter int WAIT_STATES = 0
) (
  input  logic            wb_clk_i,
  input  logic            wb_rst_i,
  input  logic [AW-1:0]   wb_adr_i,
  input  logic [DW-1:0]   wb_dat_i,
  input  logic [DW/8-1:0] wb_sel_i,
  input  logic            wb_we_i,
  input  logic            wb_cyc_i,
  input  logic            wb_stb_i,
  input  logic [2:0]      wb_cti_i,
  input  logic [1:0]      wb_bte_i,
  output logic [DW-1:0]   wb_dat_o,
  output logic            wb_ack_o,
  output logic            wb_err_o,
  output logic            wb_rty_o
);

  localparam int BW  = DW / 8;
  localparam int OFF = $clog2(BW);
  localparam int IXW = AW - OFF;
  localparam int IW  = $clog2(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_ACK
  } state_t;

  state_t         state, state_nx;
  logic [3:0]     wait_cnt, wait_cnt_nx;
  logic [IXW-1:0] pred_idx, pred_idx_nx;
  logic [IXW-1:0] cur_idx;
  logic [IXW-1:0] wrap_mask;
  logic [IXW-1:0] burst_next;
  logic           in_range;
  logic           addr_miss;
  logic           ack_r;
  logic           beat_done;
  logic           unused_adr_lsb;
  logic [DW-1:0]  mem [DEPTH];

  // The byte offset inside a word never selects anything; only the word index matters.
  assign cur_idx        = wb_adr_i[AW-1:OFF];
  assign unused_adr_lsb = ^wb_adr_i[OFF-1:0];
  assign in_range       = ({1'b0, cur_idx} < (IXW+1)'(DEPTH));

  // Wrap bursts only count within the low bits of the index; linear counts through all of them.
  always_comb begin
    wrap_mask = '1;
    case (wb_bte_i)
      2'b01:   wrap_mask = IXW'(3);
      2'b10:   wrap_mask = IXW'(7);
      2'b11:   wrap_mask = IXW'(15);
      default: wrap_mask = '1;
    endcase
  end

  assign burst_next = (pred_idx & ~wrap_mask) | ((pred_idx + IXW'(1)) & wrap_mask);

  // A strobed address that differs from the predicted one is a new access, not a beat.
  assign addr_miss = (state == S_ACK) && wb_stb_i && (cur_idx != pred_idx);
  assign ack_r     = (state == S_ACK) && !addr_miss;
  assign beat_done = ack_r && wb_cyc_i && wb_stb_i;

  assign wb_ack_o = beat_done && in_range;
  assign wb_err_o = beat_done && !in_range;
  assign wb_rty_o = 1'b0;
  assign wb_dat_o = wb_ack_o ? mem[pred_idx[IW-1:0]] : '0;

  // Next-state logic: wait-state countdown, burst tracking and exit conditions.
  always_comb begin
    state_nx    = state;
    wait_cnt_nx = wait_cnt;
    pred_idx_nx = pred_idx;
    case (state)
      S_IDLE: begin
        if (wb_cyc_i && wb_stb_i) begin
          wait_cnt_nx = 4'(WAIT_STATES);
          pred_idx_nx = cur_idx;
          state_nx    = (WAIT_STATES == 0) ? S_ACK : S_WAIT;
        end
      end
      S_WAIT: begin
        if (!wb_cyc_i) begin
          state_nx = S_IDLE;
        end else if (wait_cnt <= 4'd1) begin
          wait_cnt_nx = '0;
          state_nx    = S_ACK;
        end else begin
          wait_cnt_nx = wait_cnt - 4'd1;
        end
      end
      S_ACK: begin
        if (!wb_cyc_i) begin
          state_nx = S_IDLE;
        end else if (wb_stb_i) begin
          if (addr_miss) begin
            state_nx = S_IDLE;
          end else if (wb_cti_i == 3'b001) begin
            state_nx = S_ACK;
          end else if (wb_cti_i == 3'b010) begin
            state_nx    = S_ACK;
            pred_idx_nx = burst_next;
          end else begin
            state_nx = S_IDLE;
          end
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // State register; reset forces IDLE so ack/err fall as soon as reset rises.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state    <= S_IDLE;
      wait_cnt <= '0;
      pred_idx <= '0;
    end else begin
      state    <= state_nx;
      wait_cnt <= wait_cnt_nx;
      pred_idx <= pred_idx_nx;
    end
  end

  // Byte-lane writes on each acked write beat; contents survive reset.
  always_ff @(posedge wb_clk_i) begin
    if (wb_ack_o && wb_we_i) begin
      for (int b = 0; b < BW; b++) begin
        if (wb_sel_i[b]) begin
          mem[pred_idx[IW-1:0]][b*8 +: 8] <= wb_dat_i[b*8 +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_wb_burst_mem_slave.sv
// tb_wb_burst_mem_slave: scoreboard bench for wb_burst_mem_slave; two instances
// (0 and 3 wait states) share one bus, each test watches the instance it targets.
module tb_wb_burst_mem_slave;

  localparam int DW    = 32;
  localparam int AW    = 32;
  localparam int DEPTH = 64;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] adr;
  logic [31:0] dat_w;
  logic [3:0]  sel;
  logic        we;
  logic        cyc;
  logic        stb;
  logic [2:0]  cti;
  logic [1:0]  bte;

  logic [31:0] dat0, dat3;
  logic        ack0, err0, rty0;
  logic        ack3, err3, rty3;

  int          checks = 0;
  int          failures = 0;
  logic [31:0] model_mem [DEPTH];
  logic [31:0] exp_q [$];

  // Free-running bench clock.
  always #5 clk = ~clk;

  wb_burst_mem_slave #(.DW(DW), .AW(AW), .DEPTH(DEPTH), .WAIT_STATES(0)) dut0 (
    .wb_clk_i(clk), .wb_rst_i(rst), .wb_adr_i(adr), .wb_dat_i(dat_w), .wb_sel_i(sel),
    .wb_we_i(we), .wb_cyc_i(cyc), .wb_stb_i(stb), .wb_cti_i(cti), .wb_bte_i(bte),
    .wb_dat_o(dat0), .wb_ack_o(ack0), .wb_err_o(err0), .wb_rty_o(rty0)
  );

  wb_burst_mem_slave #(.DW(DW), .AW(AW), .DEPTH(DEPTH), .WAIT_STATES(3)) dut3 (
    .wb_clk_i(clk), .wb_rst_i(rst), .wb_adr_i(adr), .wb_dat_i(dat_w), .wb_sel_i(sel),
    .wb_we_i(we), .wb_cyc_i(cyc), .wb_stb_i(stb), .wb_cti_i(cti), .wb_bte_i(bte),
    .wb_dat_o(dat3), .wb_ack_o(ack3), .wb_err_o(err3), .wb_rty_o(rty3)
  );

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_idle();
    cyc = 1'b0; stb = 1'b0; we = 1'b0; adr = '0; dat_w = '0;
    sel = '0; cti = 3'b000; bte = 2'b00;
  endtask

  task automatic set_bus(input logic [31:0] a, input logic w, input logic [31:0] d,
                         input logic [3:0] s, input logic [2:0] c, input logic [1:0] b);
    cyc = 1'b1; stb = 1'b1; adr = a; we = w; dat_w = d; sel = s; cti = c; bte = b;
  endtask

  // Classic single access; lat counts cycles from driving stb to termination (-1 = none).
  task automatic classic_xfer(input bit ws3, input logic [31:0] a, input logic w,
                              input logic [31:0] d, input logic [3:0] s,
                              output int lat, output logic [31:0] rdata,
                              output logic ackv, output logic errv);
    bit done;
    done = 1'b0; lat = -1; rdata = '0; ackv = 1'b0; errv = 1'b0;
    set_bus(a, w, d, s, 3'b000, 2'b00);
    for (int n = 0; n < 32 && !done; n++) begin
      @(negedge clk);
      if (ws3 ? (ack3 || err3) : (ack0 || err0)) begin
        done  = 1'b1;
        lat   = n;
        rdata = ws3 ? dat3 : dat0;
        ackv  = ws3 ? ack3 : ack0;
        errv  = ws3 ? err3 : err0;
      end else begin
        next_cycle();
      end
    end
    next_cycle();
    bus_idle();
    next_cycle();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus_idle();
    repeat (2) @(posedge clk);
    #1;
    set_bus(32'h10, 1'b0, '0, 4'hF, 3'b000, 2'b00);
    @(negedge clk);
    checks++; if (ack0 !== 1'b0) begin failures++; $display("[TB] FAIL reset_ack: got %b expected 0", ack0); end
    checks++; if (err0 !== 1'b0) begin failures++; $display("[TB] FAIL reset_err: got %b expected 0", err0); end
    checks++; if (rty0 !== 1'b0) begin failures++; $display("[TB] FAIL reset_rty: got %b expected 0", rty0); end
    checks++; if (dat0 !== 32'h0) begin failures++; $display("[TB] FAIL reset_dat: got %h expected 0", dat0); end
    checks++; if (ack3 !== 1'b0 || rty3 !== 1'b0) begin failures++; $display("[TB] FAIL reset_ws3: got ack=%b rty=%b expected 0", ack3, rty3); end
    next_cycle();
    bus_idle();
    rst = 1'b0;
    next_cycle();
  endtask

  task automatic test_fill();
    int          fill_idx [10] = '{0, 1, 14, 15, 16, 17, 18, 19, 24, 63};
    int          lat;
    logic [31:0] rd, v;
    logic        a, e;
    for (int i = 0; i < 10; i++) begin
      v = $urandom;
      classic_xfer(1'b0, 32'(fill_idx[i]) << 2, 1'b1, v, 4'hF, lat, rd, a, e);
      model_mem[fill_idx[i]] = v;
      checks++;
      if (a !== 1'b1 || lat != 1) begin
        failures++; $display("[TB] FAIL fill_ack idx=%0d: got ack=%b lat=%0d expected ack=1 lat=1", fill_idx[i], a, lat);
      end
    end
  endtask

  task automatic test_classic();
    int          lat;
    logic [31:0] rd, exp_v;
    logic        a, e;
    classic_xfer(1'b0, 32'h10, 1'b1, 32'hDEADBEEF, 4'hF, lat, rd, a, e);
    model_mem[4] = 32'hDEADBEEF;
    checks++; if (a !== 1'b1 || lat != 1) begin failures++; $display("[TB] FAIL classic_wr: got ack=%b lat=%0d expected ack=1 lat=1", a, lat); end
    exp_q.push_back(model_mem[4]);
    classic_xfer(1'b0, 32'h10, 1'b0, '0, 4'hF, lat, rd, a, e);
    exp_v = exp_q.pop_front();
    checks++; if (a !== 1'b1 || lat != 1) begin failures++; $display("[TB] FAIL classic_rd_lat: got ack=%b lat=%0d expected ack=1 lat=1", a, lat); end
    checks++; if (rd !== exp_v) begin failures++; $display("[TB] FAIL classic_rd_data: got %h expected %h", rd, exp_v); end
  endtask

  task automatic test_byte_lanes();
    int          lat;
    logic [31:0] rd, exp_v;
    logic        a, e;
    classic_xfer(1'b0, 32'h20, 1'b1, 32'h11223344, 4'hF, lat, rd, a, e);
    classic_xfer(1'b0, 32'h20, 1'b1, 32'hAABBCCDD, 4'b0101, lat, rd, a, e);
    model_mem[8] = 32'h11BB33DD;
    exp_q.push_back(model_mem[8]);
    classic_xfer(1'b0, 32'h20, 1'b0, '0, 4'hF, lat, rd, a, e);
    exp_v = exp_q.pop_front();
    checks++; if (a !== 1'b1 || rd !== exp_v) begin failures++; $display("[TB] FAIL byte_lanes: got ack=%b data=%h expected ack=1 data=%h", a, rd, exp_v); end
  endtask

  task automatic test_wait_states();
    int          lat;
    logic [31:0] rd, exp_v;
    logic        a, e;
    classic_xfer(1'b1, 32'hC0, 1'b1, 32'h5A5A1234, 4'hF, lat, rd, a, e);
    model_mem[48] = 32'h5A5A1234;
    checks++; if (a !== 1'b1 || lat != 4) begin failures++; $display("[TB] FAIL ws3_wr_lat: got ack=%b lat=%0d expected ack=1 lat=4", a, lat); end
    exp_q.push_back(model_mem[48]);
    classic_xfer(1'b1, 32'hC0, 1'b0, '0, 4'hF, lat, rd, a, e);
    exp_v = exp_q.pop_front();
    checks++; if (lat != 4) begin failures++; $display("[TB] FAIL ws3_rd_lat: got %0d expected 4", lat); end
    checks++; if (rd !== exp_v) begin failures++; $display("[TB] FAIL ws3_rd_data: got %h expected %h", rd, exp_v); end
  endtask

  task automatic test_wrap4_burst();
    logic [31:0] addrs [4] = '{32'h18, 32'h1C, 32'h10, 32'h14};
    logic [31:0] wdat  [4] = '{32'hA0A00001, 32'hA0A00002, 32'hA0A00003, 32'hA0A00004};
    int          lat;
    logic [31:0] rd, exp_v;
    logic        a, e;
    set_bus(addrs[0], 1'b1, wdat[0], 4'hF, 3'b010, 2'b01);
    @(negedge clk);
    checks++; if (ack0 !== 1'b0) begin failures++; $display("[TB] FAIL wrap4_pre: got ack=%b expected 0", ack0); end
    next_cycle();
    for (int b = 0; b < 4; b++) begin
      @(negedge clk);
      model_mem[addrs[b] >> 2] = wdat[b];
      checks++; if (ack0 !== 1'b1) begin failures++; $display("[TB] FAIL wrap4_beat%0d: got ack=%b expected 1", b, ack0); end
      next_cycle();
      if (b < 3) set_bus(addrs[b+1], 1'b1, wdat[b+1], 4'hF, (b == 2) ? 3'b111 : 3'b010, 2'b01);
    end
    bus_idle();
    next_cycle();
    for (int b = 0; b < 4; b++) begin
      exp_q.push_back(model_mem[addrs[b] >> 2]);
      classic_xfer(1'b0, addrs[b], 1'b0, '0, 4'hF, lat, rd, a, e);
      exp_v = exp_q.pop_front();
      checks++; if (a !== 1'b1 || rd !== exp_v) begin failures++; $display("[TB] FAIL wrap4_readback%0d: got ack=%b data=%h expected ack=1 data=%h", b, a, rd, exp_v); end
    end
  endtask

  task automatic test_wrap16_read();
    int          idx [4] = '{14, 15, 0, 1};
    logic [31:0] exp_v;
    set_bus(32'h38, 1'b0, '0, 4'hF, 3'b010, 2'b11);
    exp_q.push_back(model_mem[idx[0]]);
    next_cycle();
    for (int b = 0; b < 4; b++) begin
      @(negedge clk);
      exp_v = exp_q.pop_front();
      checks++; if (ack0 !== 1'b1 || dat0 !== exp_v) begin failures++; $display("[TB] FAIL wrap16_beat%0d: got ack=%b data=%h expected ack=1 data=%h", b, ack0, dat0, exp_v); end
      next_cycle();
      if (b < 3) begin
        set_bus(32'(idx[b+1]) << 2, 1'b0, '0, 4'hF, (b == 2) ? 3'b111 : 3'b010, 2'b11);
        exp_q.push_back(model_mem[idx[b+1]]);
      end
    end
    bus_idle();
    next_cycle();
  endtask

  task automatic test_stall();
    logic [31:0] exp_v;
    set_bus(32'h40, 1'b0, '0, 4'hF, 3'b010, 2'b00);
    exp_q.push_back(model_mem[16]);
    next_cycle();
    @(negedge clk);
    exp_v = exp_q.pop_front();
    checks++; if (ack0 !== 1'b1 || dat0 !== exp_v) begin failures++; $display("[TB] FAIL stall_beat0: got ack=%b data=%h expected ack=1 data=%h", ack0, dat0, exp_v); end
    next_cycle();
    set_bus(32'h44, 1'b0, '0, 4'hF, 3'b010, 2'b00);
    exp_q.push_back(model_mem[17]);
    @(negedge clk);
    exp_v = exp_q.pop_front();
    checks++; if (ack0 !== 1'b1 || dat0 !== exp_v) begin failures++; $display("[TB] FAIL stall_beat1: got ack=%b data=%h expected ack=1 data=%h", ack0, dat0, exp_v); end
    next_cycle();
    set_bus(32'h48, 1'b0, '0, 4'hF, 3'b010, 2'b00);
    stb = 1'b0;
    for (int s = 0; s < 2; s++) begin
      @(negedge clk);
      checks++; if (ack0 !== 1'b0 || err0 !== 1'b0) begin failures++; $display("[TB] FAIL stall_quiet%0d: got ack=%b err=%b expected 0", s, ack0, err0); end
      next_cycle();
    end
    stb = 1'b1;
    exp_q.push_back(model_mem[18]);
    @(negedge clk);
    exp_v = exp_q.pop_front();
    checks++; if (ack0 !== 1'b1 || dat0 !== exp_v) begin failures++; $display("[TB] FAIL stall_resume: got ack=%b data=%h expected ack=1 data=%h", ack0, dat0, exp_v); end
    next_cycle();
    set_bus(32'h4C, 1'b0, '0, 4'hF, 3'b111, 2'b00);
    exp_q.push_back(model_mem[19]);
    @(negedge clk);
    exp_v = exp_q.pop_front();
    checks++; if (ack0 !== 1'b1 || dat0 !== exp_v) begin failures++; $display("[TB] FAIL stall_last: got ack=%b data=%h expected ack=1 data=%h", ack0, dat0, exp_v); end
    next_cycle();
    bus_idle();
    next_cycle();
  endtask

  task automatic test_mismatch();
    logic [31:0] exp_v;
    set_bus(32'h40, 1'b0, '0, 4'hF, 3'b010, 2'b00);
    exp_q.push_back(model_mem[16]);
    next_cycle();
    @(negedge clk);
    exp_v = exp_q.pop_front();
    checks++; if (ack0 !== 1'b1 || dat0 !== exp_v) begin failures++; $display("[TB] FAIL mismatch_beat0: got ack=%b data=%h expected ack=1 data=%h", ack0, dat0, exp_v); end
    next_cycle();
    set_bus(32'h60, 1'b0, '0, 4'hF, 3'b010, 2'b00);
    exp_q.push_back(model_mem[24]);
    @(negedge clk);
    checks++; if (ack0 !== 1'b0 || err0 !== 1'b0) begin failures++; $display("[TB] FAIL mismatch_drop: got ack=%b err=%b expected 0", ack0, err0); end
    next_cycle();
    @(negedge clk);
    checks++; if (ack0 !== 1'b0) begin failures++; $display("[TB] FAIL mismatch_relatch: got ack=%b expected 0", ack0); end
    next_cycle();
    @(negedge clk);
    exp_v = exp_q.pop_front();
    checks++; if (ack0 !== 1'b1 || dat0 !== exp_v) begin failures++; $display("[TB] FAIL mismatch_fresh: got ack=%b data=%h expected ack=1 data=%h", ack0, dat0, exp_v); end
    next_cycle();
    bus_idle();
    next_cycle();
  endtask

  task automatic test_range();
    int          lat;
    logic [31:0] rd, exp_v;
    logic        a, e;
    classic_xfer(1'b0, 32'(DEPTH) << 2, 1'b1, 32'hCAFEF00D, 4'hF, lat, rd, a, e);
    checks++; if (e !== 1'b1 || a !== 1'b0) begin failures++; $display("[TB] FAIL range_wr: got ack=%b err=%b expected ack=0 err=1", a, e); end
    classic_xfer(1'b0, 32'(DEPTH) << 2, 1'b0, '0, 4'hF, lat, rd, a, e);
    checks++; if (e !== 1'b1 || rd !== 32'h0) begin failures++; $display("[TB] FAIL range_rd: got err=%b data=%h expected err=1 data=0", e, rd); end
    exp_q.push_back(model_mem[0]);
    classic_xfer(1'b0, 32'h0, 1'b0, '0, 4'hF, lat, rd, a, e);
    exp_v = exp_q.pop_front();
    checks++; if (a !== 1'b1 || rd !== exp_v) begin failures++; $display("[TB] FAIL range_mem_kept: got ack=%b data=%h expected ack=1 data=%h", a, rd, exp_v); end
    set_bus(32'(DEPTH - 1) << 2, 1'b0, '0, 4'hF, 3'b010, 2'b00);
    exp_q.push_back(model_mem[DEPTH-1]);
    next_cycle();
    @(negedge clk);
    exp_v = exp_q.pop_front();
    checks++; if (ack0 !== 1'b1 || dat0 !== exp_v) begin failures++; $display("[TB] FAIL cross_last: got ack=%b data=%h expected ack=1 data=%h", ack0, dat0, exp_v); end
    next_cycle();
    set_bus(32'(DEPTH) << 2, 1'b0, '0, 4'hF, 3'b111, 2'b00);
    @(negedge clk);
    checks++; if (err0 !== 1'b1 || ack0 !== 1'b0 || dat0 !== 32'h0) begin failures++; $display("[TB] FAIL cross_err: got ack=%b err=%b data=%h expected ack=0 err=1 data=0", ack0, err0, dat0); end
    next_cycle();
    bus_idle();
    next_cycle();
  endtask

  task automatic test_reset_mid_burst();
    int          lat;
    logic [31:0] rd, exp_v;
    logic        a, e;
    set_bus(32'h40, 1'b0, '0, 4'hF, 3'b010, 2'b00);
    next_cycle();
    @(negedge clk);
    checks++; if (ack0 !== 1'b1) begin failures++; $display("[TB] FAIL rst_pre_ack: got %b expected 1", ack0); end
    rst = 1'b1;
    #1;
    checks++; if (ack0 !== 1'b0 || err0 !== 1'b0 || dat0 !== 32'h0) begin failures++; $display("[TB] FAIL rst_async: got ack=%b err=%b data=%h expected all 0", ack0, err0, dat0); end
    next_cycle();
    bus_idle();
    rst = 1'b0;
    next_cycle();
    exp_q.push_back(model_mem[16]);
    classic_xfer(1'b0, 32'h40, 1'b0, '0, 4'hF, lat, rd, a, e);
    exp_v = exp_q.pop_front();
    checks++; if (a !== 1'b1 || rd !== exp_v) begin failures++; $display("[TB] FAIL rst_mem_kept0: got ack=%b data=%h expected ack=1 data=%h", a, rd, exp_v); end
    exp_q.push_back(model_mem[4]);
    classic_xfer(1'b0, 32'h10, 1'b0, '0, 4'hF, lat, rd, a, e);
    exp_v = exp_q.pop_front();
    checks++; if (a !== 1'b1 || rd !== exp_v) begin failures++; $display("[TB] FAIL rst_mem_kept1: got ack=%b data=%h expected ack=1 data=%h", a, rd, exp_v); end
  endtask

  // Runs every scenario in order, then reports the totals.
  initial begin
    $display("[TB] starting wb_burst_mem_slave bench");
    test_reset();
    test_fill();
    test_classic();
    test_byte_lanes();
    test_wait_states();
    test_wrap4_burst();
    test_wrap16_read();
    test_stall();
    test_mismatch();
    test_range();
    test_reset_mid_burst();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/wb_burst_mem_slave.md
# wb_burst_mem_slave

Parametrised Wishbone B3 slave memory model, the successor to the single-width BFM memory used by the transactor benches. It supports configurable data width, depth, wait states, registered-feedback bursts (CTI/BTE with linear and wrap-4/8/16), and error responses for out-of-range accesses. It sits on the slave side of `wb_bfm_mod_transactor`-style masters in directed and random benches.

## Interface
- `DW`, 32: data width in bits; must be 32 or 64.
- `AW`, 32: address width in bits; addresses are byte addresses.
- `DEPTH`, 1024: memory depth in DW-bit words; must be a power of 2.
- `WAIT_STATES`, 0: idle cycles inserted before the first ack of each classic access or burst (0..15).
- `wb_clk_i`  in  1  clock.
- `wb_rst_i`  in  1  reset; asynchronous, active-high.
- `wb_adr_i`  in  AW  byte address.
- `wb_dat_i`  in  DW  write data.
- `wb_sel_i`  in  DW/8  byte enables.
- `wb_we_i`  in  1  write enable.
- `wb_cyc_i`  in  1  cycle valid.
- `wb_stb_i`  in  1  strobe.
- `wb_cti_i`  in  3  cycle type identifier: 000 classic, 001 const, 010 incrementing, 111 end of burst.
- `wb_bte_i`  in  2  burst type extension: 00 linear, 01 wrap4, 10 wrap8, 11 wrap16.
- `wb_dat_o`  out  DW  read data.
- `wb_ack_o`  out  1  normal termination.
- `wb_err_o`  out  1  error termination.
- `wb_rty_o`  out  1  tied to 0.

## Operation
- Word index = `wb_adr_i[AW-1:log2(DW/8)]`. If the index is DEPTH or greater, the access is out of range and terminates with err instead of ack. Out-of-range accesses never write memory and return `wb_dat_o` = 0.
- Writes update each byte lane whose `wb_sel_i` bit is set, on the ack edge. Reads return `mem[idx]`. `wb_dat_o` is 0 whenever ack is low.
- FSM states:
  - IDLE: on cyc&stb, load the wait counter with WAIT_STATES and latch the index. Go to WAIT, or to ACK if WAIT_STATES = 0.
  - WAIT: decrement the counter; go to ACK at 0.
  - ACK: internal `ack_r` = 1. `wb_ack_o` = `ack_r & cyc & stb & in_range`. `wb_err_o` = `ack_r & cyc & stb & !in_range`.
- ACK exit rules:
  - Classic (cti 000), or cti 111: after one beat, return to IDLE. `ack_r` is low for at least one cycle before the next access.
  - cti 001 or 010: stay in ACK and advance the predicted index on every terminated beat.
    - 001: index unchanged.
    - 010 linear: index + 1.
    - 010 wrapN: low log2(N) bits increment modulo N; upper bits are held.
- Each cycle in ACK (burst), compare `wb_adr_i` against the predicted index. On mismatch, drop `ack_r`, return to IDLE, and treat the presented address as a new access (WAIT_STATES applies again).
- A master stall (stb low with cyc high) holds ACK with no termination and no index advance.
- cyc low in any state returns the FSM to IDLE next edge.
- Reset mid-operation: the FSM returns to IDLE, `ack_r` clears, and outputs go low immediately. Memory contents are not reset.

## Timing
- Reset values: `wb_ack_o`, `wb_err_o`, `wb_rty_o` are 0; `wb_dat_o` is 0; FSM is IDLE; wait counter is 0.
- First-beat latency: the ack is high in the (WAIT_STATES+1)th cycle after the first edge that samples cyc&stb.
- Burst beats after the first: one per cycle with no gaps while stb is held and addresses match.
- Classic back-to-back with WAIT_STATES = 0: ack in every other cycle.
- The final beat (cti 111 acked) returns the FSM to IDLE at that edge. A new cycle may start on the following edge.
- Wrap-around: wrap16 starting at index 0x0E yields indices 0E, 0F, 00, 01, … within the 16-word block.
- Linear burst crossing DEPTH-1: the next index ≥ DEPTH terminates that beat with err, and the burst continues to be tracked.

## Test plan
- Classic write then read, DW=32, WAIT_STATES=0: write 0xDEADBEEF with sel=1111 to 0x10, then read 0x10. Expect ack one cycle after stb in each access and read data 0xDEADBEEF.
- Byte lanes: write 0xAABBCCDD with sel=0101 over prior 0x11223344. Read back expects 0x11BB33DD.
- Wait states: WAIT_STATES=3 classic read. Expect ack exactly 4 cycles after stb; ack low in cycles 1–3.
- Incrementing bursts, WAIT_STATES=0:
  - wrap4 write burst of 4 beats at 0x18, ack on 4 consecutive cycles. Read back confirms words at 0x18, 0x1C, 0x10, 0x14.
  - wrap16 read burst starting at index 0x0E. Expect data from indices 0E, 0F, 00, 01.
- Stall and mismatch:
  - Linear read burst with stb dropped for 2 cycles mid-burst. Expect no ack during the stall and resume with the correct next word.
  - Present a non-sequential address mid-burst. Expect ack to drop and a fresh first-beat latency.
- Range and reset:
  - Access at word index DEPTH. Expect err=1, ack=0, memory unchanged.
  - Assert `wb_rst_i` during a burst beat. Expect ack and err low immediately and memory preserved on later reads.
